// File: rtl/llsc_monitor_pkg.sv
// llsc_pkg: shared state type, default geometry and width helpers for the LL/SC reservation monitor.
package llsc_pkg;
  typedef enum logic {IDLE, RESERVED} state_t;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_GRAN_LG2 = 2;
  localparam int DEF_TIMEOUT = 255;
  localparam int TAG_W = DEF_ADDR_W - DEF_GRAN_LG2;
  function automatic int tag_w(input int addr_w, input int gran_lg2);
    return addr_w - gran_lg2;
  endfunction
  // At least one bit, so a disabled timeout still has a legal counter.
  function automatic int age_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/llsc_monitor_if.sv
// llsc_monitor_if: per-channel LL/SC/store/flush requests and reservation results.
interface llsc_monitor_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32
);
  logic [NUM_CH-1:0]        ll_valid;
  logic [NUM_CH*ADDR_W-1:0] ll_addr;
  logic [NUM_CH-1:0]        sc_valid;
  logic [NUM_CH*ADDR_W-1:0] sc_addr;
  logic [NUM_CH-1:0]        sc_ok;
  logic [NUM_CH-1:0]        st_valid;
  logic [NUM_CH*ADDR_W-1:0] st_addr;
  logic [NUM_CH-1:0]        flush;
  logic [NUM_CH-1:0]        llbit;
  modport master (
    output ll_valid, ll_addr, sc_valid, sc_addr, st_valid, st_addr, flush,
    input  sc_ok, llbit
  );
  modport slave (
    input  ll_valid, ll_addr, sc_valid, sc_addr, st_valid, st_addr, flush,
    output sc_ok, llbit
  );
endinterface

// File: rtl/llsc_monitor_entry.sv
// llsc_entry: one channel's reservation FSM with held granule tag and saturating age counter.
module llsc_entry
  import llsc_pkg::*;
#(
  parameter int TAG_BITS = TAG_W,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ll,
  input  logic                sc,
  input  logic                flush,
  input  logic                snoop_hit,
  input  logic [TAG_BITS-1:0] ll_tag,
  output logic                llbit,
  output logic [TAG_BITS-1:0] tag
);
  localparam int AGE_W = age_w(TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t state, state_nx;
  logic [TAG_BITS-1:0] tag_nx;
  logic [AGE_W-1:0] age, age_nx;
  logic arm, expire;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tag   <= '0;
      age   <= '0;
    end else begin
      state <= state_nx;
      tag   <= tag_nx;
      age   <= age_nx;
    end
  end
  // Flush and SC outrank a same-cycle LL; an LL outranks snoop and timeout.
  always_comb begin
    arm      = ll && !flush && !sc;
    expire   = (TIMEOUT != 0) && (age == AGE_LAST);
    state_nx = (flush || sc) ? IDLE :
               ll ? RESERVED :
               (state == RESERVED && (snoop_hit || expire)) ? IDLE : state;
    tag_nx   = arm ? ll_tag : tag;
    age_nx   = (arm || state_nx == IDLE) ? '0 :
               (age == '1) ? age : age + AGE_W'(1);
  end
  always_comb llbit = (state == RESERVED);
endmodule

// File: rtl/llsc_monitor.sv
// llsc_monitor: per-channel LL/SC reservation monitor with cross-channel store snooping,
// lifetime timeout and same-cycle SC answers that see WB-stage LL commits.
module llsc_monitor
  import llsc_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int GRAN_LG2 = DEF_GRAN_LG2,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input logic           clk,
  input logic           rst_n,
  llsc_monitor_if.slave bus
);
  localparam int TAG_BITS = tag_w(ADDR_W, GRAN_LG2);
  logic [TAG_BITS-1:0] ll_tag [NUM_CH];
  logic [TAG_BITS-1:0] sc_tag [NUM_CH];
  logic [TAG_BITS-1:0] st_tag [NUM_CH];
  logic [TAG_BITS-1:0] held   [NUM_CH];
  logic [NUM_CH-1:0] snoop_hit, sc_clash, llbit;
  function automatic logic [TAG_BITS-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return TAG_BITS'(a >> GRAN_LG2);
  endfunction
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ll_tag[c] = tag_of(bus.ll_addr[c*ADDR_W +: ADDR_W]);
      sc_tag[c] = tag_of(bus.sc_addr[c*ADDR_W +: ADDR_W]);
      st_tag[c] = tag_of(bus.st_addr[c*ADDR_W +: ADDR_W]);
    end
  end
  // Only other channels' stores matter; a channel's own store never breaks its reservation.
  always_comb begin
    snoop_hit = '0;
    sc_clash  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (k != c && bus.st_valid[k]) begin
          snoop_hit[c] = snoop_hit[c] | (st_tag[k] == held[c]);
          sc_clash[c]  = sc_clash[c]  | (st_tag[k] == sc_tag[c]);
        end
      end
    end
  end
  always_comb begin
    bus.sc_ok = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.sc_ok[c] = rst_n && bus.sc_valid[c] && !bus.flush[c] && !sc_clash[c] &&
                     ((llbit[c] && held[c] == sc_tag[c]) ||
                      (bus.ll_valid[c] && ll_tag[c] == sc_tag[c]));
    end
  end
  assign bus.llbit = llbit;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    llsc_entry #(
      .TAG_BITS(TAG_BITS),
      .TIMEOUT (TIMEOUT)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .ll       (bus.ll_valid[g]),
      .sc       (bus.sc_valid[g]),
      .flush    (bus.flush[g]),
      .snoop_hit(snoop_hit[g]),
      .ll_tag   (ll_tag[g]),
      .llbit    (llbit[g]),
      .tag      (held[g])
    );
  end
endmodule
